// File: rtl/stream_demux2_if.sv
// Handshake bundle for stream_demux2: one valid/ready input stream, two output channels, stats counts.
// The DUT attaches through the slave modport; the upstream/consumer side uses master.
interface stream_demux2_if #(
  parameter int unsigned WIDTH = 8
) ();
  localparam int unsigned CNT_W = 16;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             sel;

  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] a_data;

  logic             b_valid;
  logic             b_ready;
  logic [WIDTH-1:0] b_data;

  logic [CNT_W-1:0] a_count;
  logic [CNT_W-1:0] b_count;

  modport master (
    output in_valid, in_data, sel, a_ready, b_ready,
    input  in_ready, a_valid, a_data, b_valid, b_data, a_count, b_count
  );

  modport slave (
    input  in_valid, in_data, sel, a_ready, b_ready,
    output in_ready, a_valid, a_data, b_valid, b_data, a_count, b_count
  );
endinterface

// File: rtl/stream_demux2.sv
// Registered 1-to-2 stream demultiplexer: sel=1 steers a word into channel A, sel=0 into channel B.
// Optional per-channel accept counters are compiled in with `DEMUX_STATS_EN; otherwise counts read 0.
module stream_demux2 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  stream_demux2_if.slave  bus
);
  localparam int unsigned CNT_W = 16;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } chan_state_e;

  chan_state_e      r_a_state;
  chan_state_e      w_a_state_nxt;
  chan_state_e      r_b_state;
  chan_state_e      w_b_state_nxt;
  logic [WIDTH-1:0] r_a_data;
  logic [WIDTH-1:0] w_a_data_nxt;
  logic [WIDTH-1:0] r_b_data;
  logic [WIDTH-1:0] w_b_data_nxt;

  logic w_a_free;
  logic w_b_free;
  logic w_in_ready;
  logic w_xfer;
  logic w_load_a;
  logic w_load_b;

  // A channel can take a word if it is empty or is being drained this cycle.
  always_comb begin
    w_a_free   = (r_a_state == ST_EMPTY) || bus.a_ready;
    w_b_free   = (r_b_state == ST_EMPTY) || bus.b_ready;
    w_in_ready = bus.sel ? w_a_free : w_b_free;
    w_xfer     = bus.in_valid && w_in_ready;
    w_load_a   = w_xfer && bus.sel;
    w_load_b   = w_xfer && !bus.sel;
  end

  always_comb begin
    w_a_state_nxt = r_a_state;
    w_a_data_nxt  = r_a_data;
    case (r_a_state)
      ST_EMPTY: begin
        if (w_load_a) begin
          w_a_state_nxt = ST_FULL;
          w_a_data_nxt  = bus.in_data;
        end
      end
      ST_FULL: begin
        if (w_load_a) begin
          w_a_state_nxt = ST_FULL;
          w_a_data_nxt  = bus.in_data;
        end else if (bus.a_ready) begin
          w_a_state_nxt = ST_EMPTY;
        end
      end
    endcase
  end

  always_comb begin
    w_b_state_nxt = r_b_state;
    w_b_data_nxt  = r_b_data;
    case (r_b_state)
      ST_EMPTY: begin
        if (w_load_b) begin
          w_b_state_nxt = ST_FULL;
          w_b_data_nxt  = bus.in_data;
        end
      end
      ST_FULL: begin
        if (w_load_b) begin
          w_b_state_nxt = ST_FULL;
          w_b_data_nxt  = bus.in_data;
        end else if (bus.b_ready) begin
          w_b_state_nxt = ST_EMPTY;
        end
      end
    endcase
  end

  // Reset drops held words and any word offered in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_state <= ST_EMPTY;
      r_b_state <= ST_EMPTY;
      r_a_data  <= '0;
      r_b_data  <= '0;
    end else begin
      r_a_state <= w_a_state_nxt;
      r_b_state <= w_b_state_nxt;
      r_a_data  <= w_a_data_nxt;
      r_b_data  <= w_b_data_nxt;
    end
  end

`ifdef DEMUX_STATS_EN
  logic [CNT_W-1:0] r_a_count;
  logic [CNT_W-1:0] r_b_count;

  // Free-running accept counters; natural 16-bit wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_count <= '0;
      r_b_count <= '0;
    end else begin
      if (w_load_a) r_a_count <= r_a_count + CNT_W'(1);
      if (w_load_b) r_b_count <= r_b_count + CNT_W'(1);
    end
  end

  assign bus.a_count = r_a_count;
  assign bus.b_count = r_b_count;
`else
  assign bus.a_count = CNT_W'(0);
  assign bus.b_count = CNT_W'(0);
`endif

  assign bus.in_ready = w_in_ready;
  assign bus.a_valid  = (r_a_state == ST_FULL);
  assign bus.a_data   = r_a_data;
  assign bus.b_valid  = (r_b_state == ST_FULL);
  assign bus.b_data   = r_b_data;
endmodule

// File: tb/tb_stream_demux2.sv
// Bench for stream_demux2: directed scenarios plus a random run against a queue-based channel model.
// Count expectations follow `DEMUX_STATS_EN the same way the design does.
module tb_stream_demux2;
  localparam int unsigned WIDTH = 8;
`ifdef DEMUX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stream_demux2_if #(.WIDTH(WIDTH)) sd_if ();

  stream_demux2 #(.WIDTH(WIDTH)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (sd_if)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Each channel is a queue holding at most one word.
  logic [WIDTH-1:0] qa[$];
  logic [WIDTH-1:0] qb[$];
  logic [WIDTH-1:0] last_a, last_b;
  logic [15:0]      m_a_cnt, m_b_cnt;
  logic             obs_in_ready, exp_in_ready;

  function automatic logic [15:0] exp_cnt(input logic [15:0] c);
    return STATS ? c : 16'h0000;
  endfunction

  // Advance one clock: sample in_ready before the edge, update the model, return at posedge+1.
  task automatic tick();
    logic a_pop, b_pop;
    @(negedge clk);
    obs_in_ready = sd_if.in_ready;
    exp_in_ready = sd_if.sel ? (qa.size() == 0 || sd_if.a_ready) : (qb.size() == 0 || sd_if.b_ready);
    if (rst) begin
      qa.delete(); qb.delete();
      last_a = '0; last_b = '0;
      m_a_cnt = '0; m_b_cnt = '0;
    end else begin
      a_pop = (qa.size() != 0) && sd_if.a_ready;
      b_pop = (qb.size() != 0) && sd_if.b_ready;
      if (a_pop) void'(qa.pop_front());
      if (b_pop) void'(qb.pop_front());
      if (sd_if.in_valid && exp_in_ready) begin
        if (sd_if.sel) begin qa.push_back(sd_if.in_data); last_a = sd_if.in_data; m_a_cnt++; end
        else           begin qb.push_back(sd_if.in_data); last_b = sd_if.in_data; m_b_cnt++; end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic [WIDTH-1:0] d,
                       input logic ar, input logic br);
    sd_if.in_valid = v; sd_if.sel = s; sd_if.in_data = d;
    sd_if.a_ready = ar; sd_if.b_ready = br;
  endtask

  task automatic do_reset();
    rst = 1'b1; drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 1'b1, 8'hFF, 1'b0, 1'b0);
    tick();
    sd_if.sel = 1'b0;
    tick();
    n_cmp++; if (sd_if.a_valid !== 1'b0) begin n_err++; $display("FAIL reset_a_valid got %0b exp 0", sd_if.a_valid); end
    n_cmp++; if (sd_if.b_valid !== 1'b0) begin n_err++; $display("FAIL reset_b_valid got %0b exp 0", sd_if.b_valid); end
    n_cmp++; if (sd_if.a_data !== 8'h00) begin n_err++; $display("FAIL reset_a_data got %h exp 00", sd_if.a_data); end
    n_cmp++; if (sd_if.b_data !== 8'h00) begin n_err++; $display("FAIL reset_b_data got %h exp 00", sd_if.b_data); end
    n_cmp++; if (sd_if.a_count !== 16'h0) begin n_err++; $display("FAIL reset_a_count got %h exp 0", sd_if.a_count); end
    n_cmp++; if (sd_if.b_count !== 16'h0) begin n_err++; $display("FAIL reset_b_count got %h exp 0", sd_if.b_count); end
    n_cmp++; if (sd_if.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %0b exp 1", sd_if.in_ready); end
    rst = 1'b0;
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    tick();
    n_cmp++; if (sd_if.a_valid !== 1'b0 || sd_if.b_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_no_load got a=%0b b=%0b exp 0 0", sd_if.a_valid, sd_if.b_valid); end
  endtask

  task automatic test_routing();
    drive(1'b1, 1'b1, 8'h5A, 1'b1, 1'b1);
    tick();
    n_cmp++; if (sd_if.a_valid !== 1'b1 || sd_if.a_data !== 8'h5A) begin
      n_err++; $display("FAIL route_a got v=%0b d=%h exp v=1 d=5a", sd_if.a_valid, sd_if.a_data); end
    n_cmp++; if (sd_if.b_valid !== 1'b0) begin n_err++; $display("FAIL route_a_other got b_valid=%0b exp 0", sd_if.b_valid); end
    drive(1'b1, 1'b0, 8'hA5, 1'b1, 1'b1);
    tick();
    n_cmp++; if (sd_if.b_valid !== 1'b1 || sd_if.b_data !== 8'hA5) begin
      n_err++; $display("FAIL route_b got v=%0b d=%h exp v=1 d=a5", sd_if.b_valid, sd_if.b_data); end
    n_cmp++; if (sd_if.a_valid !== 1'b0) begin n_err++; $display("FAIL route_b_other got a_valid=%0b exp 0", sd_if.a_valid); end
    drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
    tick();
  endtask

  task automatic test_backpressure();
    drive(1'b1, 1'b1, 8'h11, 1'b0, 1'b1);
    tick();
    n_cmp++; if (sd_if.a_valid !== 1'b1 || sd_if.a_data !== 8'h11) begin
      n_err++; $display("FAIL bp_load got v=%0b d=%h exp v=1 d=11", sd_if.a_valid, sd_if.a_data); end
    drive(1'b1, 1'b1, 8'h22, 1'b0, 1'b1);
    #1;
    n_cmp++; if (sd_if.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready got %0b exp 0", sd_if.in_ready); end
    tick();
    n_cmp++; if (sd_if.a_data !== 8'h11) begin n_err++; $display("FAIL bp_hold got %h exp 11", sd_if.a_data); end
    drive(1'b1, 1'b0, 8'h77, 1'b0, 1'b1);
    tick();
    n_cmp++; if (obs_in_ready !== 1'b1) begin n_err++; $display("FAIL bp_b_ready got %0b exp 1", obs_in_ready); end
    n_cmp++; if (sd_if.b_valid !== 1'b1 || sd_if.b_data !== 8'h77) begin
      n_err++; $display("FAIL bp_b_pass got v=%0b d=%h exp v=1 d=77", sd_if.b_valid, sd_if.b_data); end
    n_cmp++; if (sd_if.a_data !== 8'h11 || sd_if.a_valid !== 1'b1) begin
      n_err++; $display("FAIL bp_a_still got v=%0b d=%h exp v=1 d=11", sd_if.a_valid, sd_if.a_data); end
    drive(1'b1, 1'b1, 8'h22, 1'b1, 1'b1);
    tick();
    n_cmp++; if (sd_if.a_valid !== 1'b1 || sd_if.a_data !== 8'h22) begin
      n_err++; $display("FAIL bp_release got v=%0b d=%h exp v=1 d=22", sd_if.a_valid, sd_if.a_data); end
    drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
    tick();
  endtask

  task automatic test_drain_load();
    drive(1'b1, 1'b1, 8'h33, 1'b1, 1'b1);
    tick();
    n_cmp++; if (sd_if.a_data !== 8'h33) begin n_err++; $display("FAIL dl_first got %h exp 33", sd_if.a_data); end
    drive(1'b1, 1'b1, 8'h44, 1'b1, 1'b1);
    tick();
    n_cmp++; if (sd_if.a_valid !== 1'b1 || sd_if.a_data !== 8'h44) begin
      n_err++; $display("FAIL dl_no_bubble got v=%0b d=%h exp v=1 d=44", sd_if.a_valid, sd_if.a_data); end
    drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
    tick();
  endtask

  task automatic test_stats();
    logic [15:0] e;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, (i < 3), 8'(i), 1'b1, 1'b1);
      tick();
    end
    drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
    tick();
    e = STATS ? 16'd3 : 16'd0;
    n_cmp++; if (sd_if.a_count !== e) begin n_err++; $display("FAIL stats_a3 got %0d exp %0d", sd_if.a_count, e); end
    e = STATS ? 16'd5 : 16'd0;
    n_cmp++; if (sd_if.b_count !== e) begin n_err++; $display("FAIL stats_b5 got %0d exp %0d", sd_if.b_count, e); end
    do_reset();
    for (int i = 0; i < 65535; i++) begin
      drive(1'b1, 1'b1, 8'(i), 1'b1, 1'b1);
      tick();
    end
    e = STATS ? 16'hFFFF : 16'h0000;
    n_cmp++; if (sd_if.a_count !== e) begin n_err++; $display("FAIL stats_preload got %h exp %h", sd_if.a_count, e); end
    tick();
    n_cmp++; if (sd_if.a_count !== 16'h0000) begin n_err++; $display("FAIL stats_wrap got %h exp 0000", sd_if.a_count); end
    n_cmp++; if (sd_if.b_count !== 16'h0000) begin n_err++; $display("FAIL stats_wrap_b got %h exp 0000", sd_if.b_count); end
    drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(99) == 0);
      drive(1'($urandom), 1'($urandom), 8'($urandom),
            ($urandom_range(3) != 0), ($urandom_range(3) != 0));
      tick();
      if (!rst) begin
        n_cmp++; if (obs_in_ready !== exp_in_ready) begin
          n_err++; $display("FAIL rnd_in_ready cyc %0d got %0b exp %0b", i, obs_in_ready, exp_in_ready); end
      end
      n_cmp++; if (sd_if.a_valid !== (qa.size() != 0)) begin
        n_err++; $display("FAIL rnd_a_valid cyc %0d got %0b exp %0b", i, sd_if.a_valid, qa.size() != 0); end
      n_cmp++; if (sd_if.b_valid !== (qb.size() != 0)) begin
        n_err++; $display("FAIL rnd_b_valid cyc %0d got %0b exp %0b", i, sd_if.b_valid, qb.size() != 0); end
      n_cmp++; if (sd_if.a_data !== last_a) begin
        n_err++; $display("FAIL rnd_a_data cyc %0d got %h exp %h", i, sd_if.a_data, last_a); end
      n_cmp++; if (sd_if.b_data !== last_b) begin
        n_err++; $display("FAIL rnd_b_data cyc %0d got %h exp %h", i, sd_if.b_data, last_b); end
      n_cmp++; if (sd_if.a_count !== exp_cnt(m_a_cnt) || sd_if.b_count !== exp_cnt(m_b_cnt)) begin
        n_err++; $display("FAIL rnd_counts cyc %0d got %0d/%0d exp %0d/%0d", i, sd_if.a_count, sd_if.b_count,
                          exp_cnt(m_a_cnt), exp_cnt(m_b_cnt)); end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    test_reset();
    test_routing();
    test_backpressure();
    test_drain_load();
    test_stats();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/stream_demux2.md
# stream_demux2

Registered 1-to-2 stream demultiplexer, the receive-side counterpart to the team's 2:1 `multiplexer`. It accepts one word per cycle on a valid/ready input stream and steers it by `sel` to one of two output channels, `a` or `b`. Each output channel holds one word and has its own valid/ready handshake. It sits between a shared data path and two independent consumers.

## Interface
- `WIDTH`, default 8: data width of the input and both output channels.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  synchronous, active-high reset.
- `in_valid`  input  1  input word present.
- `in_ready`  output  1  input word accepted this cycle when high with `in_valid`.
- `in_data`  input  WIDTH  input word.
- `sel`  input  1  channel select, sampled with `in_data`: 1 routes to `a`, 0 routes to `b`. Same polarity as `multiplexer`, where `sel`=1 selects `a`.
- `a_valid`  output  1  channel A holds a word.
- `a_ready`  input  1  channel A consumer accepts.
- `a_data`  output  WIDTH  channel A word.
- `b_valid`  output  1  channel B holds a word.
- `b_ready`  input  1  channel B consumer accepts.
- `b_data`  output  WIDTH  channel B word.
- `a_count`  output  16  words accepted for A (only with `DEMUX_STATS_EN`).
- `b_count`  output  16  words accepted for B (only with `DEMUX_STATS_EN`).

## Operation
- Each channel has a one-entry register with two states: EMPTY (`x_valid`=0) and FULL (`x_valid`=1).
- Channel free condition: `x_free = !x_valid || x_ready`.
- `in_ready = sel ? a_free : b_free`. This is combinational from `sel`, `a_valid`/`b_valid` and `a_ready`/`b_ready`. It does not depend on `in_valid`.
- Input transfer happens when `in_valid && in_ready`. On a transfer, the selected channel's register loads `in_data` and its valid bit is set.
- Output transfer on a channel happens when `x_valid && x_ready`. If no load to that channel occurs in the same cycle, its valid bit clears.
- Load and drain in the same cycle on the same channel: the channel stays FULL with the new data. There is no bubble.
- The unselected channel is never written. Its data and valid hold, apart from its own drain.
- A stalled channel does not block the other channel. A stalled selected channel blocks only the input.
- With `in_valid`=0, `sel` and `in_data` are don't-care and no state changes except drains.
- Output data holds while `x_valid`=1 and `x_ready`=0, and also after a drain. Data is undefined-but-stable when invalid, and is in practice the last loaded value.

## Timing
- Latency: a word accepted at edge N is visible on `x_data`/`x_valid` after edge N. The earliest consumer handshake is at edge N+1.
- Throughput: 1 word/cycle sustained, provided the selected consumer holds ready high. Alternating `sel` also sustains 1 word/cycle.
- Reset values (`rst` high at an edge): `a_valid`=0, `b_valid`=0, `a_data`=0, `b_data`=0, `a_count`=0, `b_count`=0.
- `in_ready` during reset equals the free condition of the cleared registers, i.e. 1. No transfer is accepted on a cycle where `rst` is high.
- Reset mid-operation discards any held words without handshake. Inputs offered in the reset cycle are dropped.

## Configuration
- `DEMUX_STATS_EN` defined: two 16-bit counters are compiled in.
  - `a_count` increments by 1 on each input transfer routed to A; `b_count` does the same for B.
  - Counters wrap 0xFFFF -> 0x0000.
  - Counters clear on `rst`.
- `DEMUX_STATS_EN` undefined: the counter logic is absent, the ports remain, and `a_count`/`b_count` are tied to 16'h0000.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with `in_valid`=1. Required: `a_valid`=`b_valid`=0, data 0, counts 0, no load.
- Routing (WIDTH=8, both readies 1): send 0x5A with `sel`=1, then 0xA5 with `sel`=0. Required:
  - `a_data`=0x5A with `a_valid` one cycle after the first send;
  - `b_data`=0xA5 with `b_valid` one cycle after the second send;
  - the other channel's valid stays 0 in each case.
- Backpressure: set `a_ready`=0 and send 0x11 then 0x22 to A. Required:
  - `a_data` holds 0x11 and `in_ready`=0 while `sel`=1;
  - a word with `sel`=0 still passes to B;
  - after `a_ready`=1 for one cycle, 0x22 loads.
- Simultaneous drain and load: A is FULL with 0x33, `a_ready`=1, send 0x44 to A. Required: the next cycle shows `a_valid`=1 and `a_data`=0x44, with no idle cycle.
- Stats (`DEMUX_STATS_EN` defined): send 3 words to A and 5 to B. Required: `a_count`=3 and `b_count`=5. Preload 65535 transfers to A, send one more, and require `a_count`=0.
- Stats disabled: repeat the previous stimulus. Required: `a_count`=`b_count`=0 throughout.
